// File: rtl/if_stage.sv
// Instruction-fetch stage: holds one fetch entry between pre-IF and ID.
// An entry waits for its in-order SRAM response, or is an exception entry
// that needs no response. A discard counter drops responses that belong to
// requests killed by a flush.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   pre_IF_*                   entry offered by pre-IF, and its request handshake
//   IF_allow_in                this stage accepts a pre-IF entry this cycle (combinational)
//   inst_sram_data_ok/rdata    in-order instruction response
//   flush                      kill the held entry and any in-flight request
//   IF_ID_allow_in             ID accepts the entry
//   IF_ID_*                    entry presented to ID
//   pre_IF_IF_reg_valid        an entry is held
//   pre_IF_IF_reg_stall_wait_for_data  held non-exception entry still waits for data
module if_stage #(
  parameter int unsigned DISCARD_MAX = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pre_IF_valid_out,
  input  logic        pre_IF_req_issued,
  input  logic [31:0] pre_IF_pc,
  input  logic        pre_IF_exception,
  input  logic [4:0]  pre_IF_exccode,
  input  logic        pre_IF_tlb_refill,
  output logic        IF_allow_in,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        flush,
  input  logic        IF_ID_allow_in,
  output logic        IF_ID_valid,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_inst,
  output logic        IF_ID_exception,
  output logic [4:0]  IF_ID_exccode,
  output logic        IF_ID_tlb_refill,
  output logic        pre_IF_IF_reg_valid,
  output logic        pre_IF_IF_reg_stall_wait_for_data
);

  localparam int unsigned CNT_W = (DISCARD_MAX < 1) ? 1 : $clog2(DISCARD_MAX + 1);
  // Two spare bits so the pre-saturation sum cannot wrap.
  localparam int unsigned SUM_W = CNT_W + 2;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2,
    S_EXC   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic              exc_q, exc_d;
  logic [4:0]        code_q, code_d;
  logic              tlb_q, tlb_d;

  logic              out_valid;
  logic              drop;
  logic              take;
  logic              load;
  logic              leave;
  logic              inc_wait;
  logic              inc_req;
  logic [SUM_W-1:0]  cnt_sum;

  // Handshake decode shared by next-state logic and outputs.
  assign out_valid   = (state_q == S_READY) || (state_q == S_EXC);
  assign IF_allow_in = ~flush & ((state_q == S_EMPTY) | (out_valid & IF_ID_allow_in));
  assign drop        = inst_sram_data_ok & (cnt_q != '0);
  assign take        = inst_sram_data_ok & (cnt_q == '0) & (state_q == S_WAIT);
  assign load        = pre_IF_valid_out & IF_allow_in;
  assign leave       = out_valid & IF_ID_allow_in;

  // A flushed WAIT entry leaves its request in flight unless its data was
  // consumed this very cycle; a request issued alongside a flush is also orphaned.
  assign inc_wait = flush & (state_q == S_WAIT) & ~take;
  assign inc_req  = flush & pre_IF_req_issued;
  assign cnt_sum  = SUM_W'(cnt_q) + SUM_W'(inc_wait) + SUM_W'(inc_req) - SUM_W'(drop);

  // Next-state and buffer update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    exc_d   = exc_q;
    code_d  = code_q;
    tlb_d   = tlb_q;

    if (cnt_sum > SUM_W'(DISCARD_MAX)) begin
      cnt_d = CNT_W'(DISCARD_MAX);
    end else begin
      cnt_d = CNT_W'(cnt_sum);
    end

    if (flush) begin
      state_d = S_EMPTY;
    end else if (load) begin
      state_d = pre_IF_exception ? S_EXC : S_WAIT;
      pc_d    = pre_IF_pc;
      inst_d  = 32'd0;
      exc_d   = pre_IF_exception;
      code_d  = pre_IF_exccode;
      tlb_d   = pre_IF_tlb_refill;
    end else if (take) begin
      state_d = S_READY;
      inst_d  = inst_sram_rdata;
    end else if (leave) begin
      state_d = S_EMPTY;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_EMPTY;
      cnt_q   <= '0;
      pc_q    <= 32'd0;
      inst_q  <= 32'd0;
      exc_q   <= 1'b0;
      code_q  <= 5'd0;
      tlb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      exc_q   <= exc_d;
      code_q  <= code_d;
      tlb_q   <= tlb_d;
    end
  end

  assign IF_ID_valid                       = out_valid;
  assign IF_ID_pc                          = pc_q;
  assign IF_ID_inst                        = inst_q;
  assign IF_ID_exception                   = exc_q;
  assign IF_ID_exccode                     = code_q;
  assign IF_ID_tlb_refill                  = tlb_q;
  assign pre_IF_IF_reg_valid               = (state_q != S_EMPTY);
  assign pre_IF_IF_reg_stall_wait_for_data = (state_q == S_WAIT);

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed fetch scenarios followed by random traffic,
// checked against a model that tracks the held entry and a queue of
// outstanding SRAM requests tagged wanted/unwanted.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        pre_IF_valid_out;
  logic        pre_IF_req_issued;
  logic [31:0] pre_IF_pc;
  logic        pre_IF_exception;
  logic [4:0]  pre_IF_exccode;
  logic        pre_IF_tlb_refill;
  logic        IF_allow_in;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        flush;
  logic        IF_ID_allow_in;
  logic        IF_ID_valid;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_inst;
  logic        IF_ID_exception;
  logic [4:0]  IF_ID_exccode;
  logic        IF_ID_tlb_refill;
  logic        pre_IF_IF_reg_valid;
  logic        pre_IF_IF_reg_stall_wait_for_data;

  if_stage #(.DISCARD_MAX(2)) dut (
    .clk                               (clk),
    .reset                             (reset),
    .pre_IF_valid_out                  (pre_IF_valid_out),
    .pre_IF_req_issued                 (pre_IF_req_issued),
    .pre_IF_pc                         (pre_IF_pc),
    .pre_IF_exception                  (pre_IF_exception),
    .pre_IF_exccode                    (pre_IF_exccode),
    .pre_IF_tlb_refill                 (pre_IF_tlb_refill),
    .IF_allow_in                       (IF_allow_in),
    .inst_sram_data_ok                 (inst_sram_data_ok),
    .inst_sram_rdata                   (inst_sram_rdata),
    .flush                             (flush),
    .IF_ID_allow_in                    (IF_ID_allow_in),
    .IF_ID_valid                       (IF_ID_valid),
    .IF_ID_pc                          (IF_ID_pc),
    .IF_ID_inst                        (IF_ID_inst),
    .IF_ID_exception                   (IF_ID_exception),
    .IF_ID_exccode                     (IF_ID_exccode),
    .IF_ID_tlb_refill                  (IF_ID_tlb_refill),
    .pre_IF_IF_reg_valid               (pre_IF_IF_reg_valid),
    .pre_IF_IF_reg_stall_wait_for_data (pre_IF_IF_reg_stall_wait_for_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the held entry, plus every outstanding request in issue
  // order; a request is wanted only while its entry is still alive.
  bit          m_full;
  bit          m_exc;
  bit          m_data;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [4:0]  m_code;
  bit          m_tlb;
  bit          q_want[$];
  bit          just_reset;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_valid();
    return m_full && (m_exc || m_data);
  endfunction

  function automatic bit exp_wait();
    return m_full && !m_exc && !m_data;
  endfunction

  // One clock: drive at negedge, check combinational outputs, advance the
  // model at posedge, then check registered outputs at the next negedge.
  task automatic step(input bit rst, input bit pv, input bit exc,
                      input logic [31:0] pc, input logic [4:0] code, input bit tlb,
                      input bit fl, input bit req_fl, input bit dok,
                      input logic [31:0] rd, input bit ida);
    bit allow_e;
    bit load;
    bit leave;
    bit w;
    allow_e = !fl && (!m_full || (exp_valid() && ida));
    load    = !rst && !fl && pv && allow_e;

    reset             = rst;
    pre_IF_valid_out  = pv;
    pre_IF_exception  = exc;
    pre_IF_pc         = pc;
    pre_IF_exccode    = code;
    pre_IF_tlb_refill = tlb;
    flush             = fl;
    pre_IF_req_issued = rst ? 1'b0 : (fl ? req_fl : (pv && allow_e && !exc));
    inst_sram_data_ok = dok;
    inst_sram_rdata   = rd;
    IF_ID_allow_in    = ida;

    #1;
    check("allow_in", 32'(IF_allow_in), 32'(allow_e));
    check("reg_valid", 32'(pre_IF_IF_reg_valid), 32'(m_full));
    check("stall_wait", 32'(pre_IF_IF_reg_stall_wait_for_data), 32'(exp_wait()));

    @(posedge clk);
    if (rst) begin
      m_full = 0; m_exc = 0; m_data = 0; m_pc = '0; m_inst = '0; m_code = '0; m_tlb = 0;
      q_want.delete();
      just_reset = 1;
    end else begin
      just_reset = 0;
      w = 0;
      if (dok) w = q_want.pop_front();
      if (w) check("resp_while_waiting", 32'(exp_wait()), 32'd1);
      leave = exp_valid() && ida;
      if (fl) begin
        m_full = 0;
        foreach (q_want[i]) q_want[i] = 0;
        if (req_fl) q_want.push_back(0);
      end else if (load) begin
        m_full = 1; m_exc = exc; m_data = 0; m_pc = pc; m_inst = '0; m_code = code; m_tlb = tlb;
        if (!exc) q_want.push_back(1);
      end else begin
        if (w) begin
          m_data = 1;
          m_inst = rd;
        end
        if (leave) m_full = 0;
      end
    end

    @(negedge clk);
    check("id_valid", 32'(IF_ID_valid), 32'(exp_valid()));
    if (exp_valid() || just_reset) begin
      check("id_pc", IF_ID_pc, m_pc);
      check("id_inst", IF_ID_inst, m_inst);
      check("id_exception", 32'(IF_ID_exception), 32'(m_exc));
      check("id_exccode", 32'(IF_ID_exccode), 32'(m_code));
      check("id_tlb_refill", 32'(IF_ID_tlb_refill), 32'(m_tlb));
    end
  endtask

  task automatic idle(input bit ida);
    step(0, 0, 0, '0, '0, 0, 0, 0, 0, '0, ida);
  endtask

  task automatic fetch(input logic [31:0] pc, input bit ida);
    step(0, 1, 0, pc, '0, 0, 0, 0, 0, '0, ida);
  endtask

  task automatic respond(input logic [31:0] rd, input bit ida);
    step(0, 0, 0, '0, '0, 0, 0, 0, 1, rd, ida);
  endtask

  task automatic do_reset();
    step(1, 0, 0, '0, '0, 0, 0, 0, 0, '0, 1);
  endtask

  initial begin
    bit rst, pv, exc, fl, req_fl, dok, ida;
    reset = 1'b1;
    pre_IF_valid_out = 0; pre_IF_req_issued = 0; pre_IF_pc = '0; pre_IF_exception = 0;
    pre_IF_exccode = '0; pre_IF_tlb_refill = 0; flush = 0; inst_sram_data_ok = 0;
    inst_sram_rdata = '0; IF_ID_allow_in = 0;
    @(negedge clk);
    do_reset();
    do_reset();

    // Normal fetch with two-cycle response latency.
    fetch(32'hBFC00000, 0);
    idle(0);
    respond(32'h24080001, 0);
    idle(1);

    // Backpressure, then a new entry loads while the old one leaves.
    fetch(32'hBFC00004, 0);
    respond(32'h3C1D0001, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 32'hBFC00008, '0, 0, 0, 0, 0, '0, 0);
    fetch(32'hBFC00008, 1);
    respond(32'h00000000, 1);

    // Flush in WAIT with a request issued alongside: two responses dropped.
    fetch(32'hBFC00100, 0);
    step(0, 0, 0, '0, '0, 0, 1, 1, 0, '0, 0);
    respond(32'hDEADBEEF, 0);
    respond(32'hCAFEF00D, 0);
    fetch(32'hBFC00380, 0);
    respond(32'h00000000, 0);
    idle(1);

    // Exception entry needs no response.
    step(0, 1, 1, 32'hBFC00001, 5'h04, 0, 0, 0, 0, '0, 0);
    idle(1);
    step(0, 1, 1, 32'hBFC00200, 5'h02, 1, 0, 0, 0, '0, 1);
    idle(1);

    // Flush coinciding with the matching response: nothing left to discard.
    fetch(32'hBFC00010, 0);
    step(0, 0, 0, '0, '0, 0, 1, 0, 1, 32'h11111111, 0);
    fetch(32'hBFC00014, 0);
    respond(32'h22222222, 0);
    idle(1);

    // Reset while waiting with one pending discard.
    fetch(32'hBFC00020, 0);
    step(0, 0, 0, '0, '0, 0, 1, 0, 0, '0, 0);
    fetch(32'hBFC00024, 0);
    do_reset();
    idle(1);

    // Random traffic; at most two requests ever outstanding.
    for (int n = 0; n < 3000; n++) begin
      rst    = ($urandom_range(0, 199) == 0);
      fl     = ($urandom_range(0, 9) == 0);
      dok    = (q_want.size() > 0) && ($urandom_range(0, 1) == 1);
      pv     = ($urandom_range(0, 3) != 0);
      exc    = ($urandom_range(0, 5) == 0);
      if (!exc && q_want.size() >= 2) pv = 0;
      req_fl = (q_want.size() < 2) && ($urandom_range(0, 1) == 1);
      ida    = ($urandom_range(0, 3) != 0);
      step(rst, pv, exc, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
           fl, req_fl, dok, $urandom, ida);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
